// File: rtl/exec_mem_pkg.sv
// exec_mem_pkg: opcode/funct constants and control enums
// shared by the execute/memory slice.
package exec_mem_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_OR   = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_HI   = 2'b10
  } ext_op_e;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    WR_RT = 2'b00,
    WR_RD = 2'b01,
    WR_RA = 2'b10
  } wr_sel_e;

  typedef enum logic [1:0] {
    WD_ALU = 2'b00,
    WD_MEM = 2'b01,
    WD_PC4 = 2'b10
  } wd_sel_e;

endpackage

// File: rtl/exec_mem_dm.sv
// exec_mem_dm: word-addressed data memory with async clear,
// synchronous write and combinational read.
module exec_mem_dm #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [DM_AW-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DM_WORDS];

  // Clear every word while reset is high; otherwise commit stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/exec_mem_core.sv
// exec_mem_core: decoder, ALU and data memory of the single-cycle
// MIPS datapath. Define EXEC_MEM_TRACE_EN to print each store.
import exec_mem_pkg::*;

module exec_mem_core #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] ext_imm,
  input  logic [31:0] pc,
  output logic [1:0]  ext_op,
  output logic [1:0]  npc_op,
  output logic [1:0]  wr_sel,
  output logic [1:0]  wd_sel,
  output logic        rf_we,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic [31:0] mem_rdata
);

  alu_op_e     alu_op;
  ext_op_e     ext_c;
  npc_op_e     npc_c;
  wr_sel_e     wr_c;
  wd_sel_e     wd_c;
  logic        b_sel;
  logic        dm_we;
  logic        we_c;
  logic        is_beq;
  logic        is_r;
  logic [31:0] alu_b;

  // Main decoder: unlisted encodings leave every control at 0.
  always_comb begin
    alu_op = ALU_ADD;
    ext_c  = EXT_ZERO;
    npc_c  = NPC_PC4;
    wr_c   = WR_RT;
    wd_c   = WD_ALU;
    b_sel  = 1'b0;
    dm_we  = 1'b0;
    we_c   = 1'b0;
    is_beq = 1'b0;
    is_r   = (opcode == OP_RTYPE);
    unique case (1'b1)
      is_r && funct == FN_ADDU: begin
        we_c = 1'b1;
        wr_c = WR_RD;
      end
      is_r && funct == FN_SUBU: begin
        alu_op = ALU_SUB;
        we_c   = 1'b1;
        wr_c   = WR_RD;
      end
      is_r && funct == FN_JR: npc_c = NPC_JR;
      opcode == OP_ORI: begin
        alu_op = ALU_OR;
        b_sel  = 1'b1;
        we_c   = 1'b1;
      end
      opcode == OP_LW: begin
        b_sel = 1'b1;
        ext_c = EXT_SIGN;
        we_c  = 1'b1;
        wd_c  = WD_MEM;
      end
      opcode == OP_SW: begin
        b_sel = 1'b1;
        ext_c = EXT_SIGN;
        dm_we = 1'b1;
      end
      opcode == OP_BEQ: begin
        alu_op = ALU_SUB;
        is_beq = 1'b1;
      end
      opcode == OP_LUI: begin
        alu_op = ALU_PASS;
        b_sel  = 1'b1;
        ext_c  = EXT_HI;
        we_c   = 1'b1;
      end
      opcode == OP_JAL: begin
        we_c  = 1'b1;
        wr_c  = WR_RA;
        wd_c  = WD_PC4;
        npc_c = NPC_J;
      end
      opcode == OP_J: npc_c = NPC_J;
      default: ;
    endcase
  end

  // ALU: modulo-2^32 arithmetic, no overflow detection.
  always_comb begin
    alu_b = b_sel ? ext_imm : rt_val;
    unique case (alu_op)
      ALU_ADD: alu_out = rs_val + alu_b;
      ALU_SUB: alu_out = rs_val - alu_b;
      ALU_OR:  alu_out = rs_val | alu_b;
      default: alu_out = alu_b;
    endcase
  end

  assign zero   = (alu_out == 32'h0);
  assign ext_op = ext_c;
  assign wr_sel = wr_c;
  assign wd_sel = wd_c;
  assign rf_we  = we_c;
  assign npc_op = is_beq ? (zero ? NPC_BR : NPC_PC4) : npc_c;

  exec_mem_dm #(
    .DM_WORDS (DM_WORDS),
    .DM_AW    (DM_AW)
  ) u_dm (
    .clk   (clk),
    .reset (reset),
    .we    (dm_we),
    .idx   (alu_out[DM_AW+1:2]),
    .wdata (rt_val),
    .rdata (mem_rdata)
  );

`ifdef EXEC_MEM_TRACE_EN
  // Log each committed store.
  always @(posedge clk) begin
    if (!reset && dm_we)
      $display("@%08h: *%08h <= %08h", pc, alu_out, rt_val);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_exec_mem_core.sv
// tb_exec_mem_core: scoreboard bench for the decode/ALU/memory
// slice; expected results are queued as stimulus is issued.
module tb_exec_mem_core;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] LUI = 6'b001111;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] JAL = 6'b000011;
  localparam logic [5:0] ADU = 6'b100001;
  localparam logic [5:0] SBU = 6'b100011;
  localparam logic [5:0] JR  = 6'b001000;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [8:0]  ctl;
    logic [31:0] alu;
    logic        z;
  } vec_t;

  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic [31:0] alu;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [31:0] ext_imm = '0;
  logic [31:0] pc = '0;
  logic [1:0]  ext_op, npc_op, wr_sel, wd_sel;
  logic        rf_we, zero;
  logic [31:0] alu_out, mem_rdata;
  logic [8:0]  ctl;

  int n_pass = 0;
  int n_total = 0;

  exp_t        ctl_q[$];
  logic [31:0] data_q[$];

  assign ctl = {ext_op, npc_op, wr_sel, wd_sel, rf_we};

  exec_mem_core dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .ext_imm   (ext_imm),
    .pc        (pc),
    .ext_op    (ext_op),
    .npc_op    (npc_op),
    .wr_sel    (wr_sel),
    .wd_sel    (wd_sel),
    .rf_we     (rf_we),
    .alu_out   (alu_out),
    .zero      (zero),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm);
    @(negedge clk);
    opcode  = op;
    funct   = fn;
    rs_val  = rs;
    rt_val  = rt;
    ext_imm = imm;
    pc      = pc + 32'd4;
    #1;
  endtask

  task automatic test_reset();
    issue(RT, 6'b0, 32'h0, 32'h0, 32'h0);
    n_total++;
    if (ctl !== 9'h0) $display("FAIL rst_ctl got %h want 000", ctl);
    else n_pass++;
    n_total++;
    if (mem_rdata !== 32'h0)
      $display("FAIL rst_mem got %h want 00000000", mem_rdata);
    else n_pass++;
    n_total++;
    if (zero !== 1'b1) $display("FAIL rst_zero got %b want 1", zero);
    else n_pass++;
  endtask

  task automatic test_decode(input string tag, input vec_t v[]);
    exp_t e;
    foreach (v[i]) begin
      issue(v[i].op, v[i].fn, v[i].rs, v[i].rt, v[i].imm);
      ctl_q.push_back('{v[i].name, v[i].ctl, v[i].alu, v[i].z});
      e = ctl_q.pop_front();
      n_total++;
      if (ctl !== e.ctl)
        $display("FAIL %s_%s_ctl got %h want %h", tag, e.name, ctl, e.ctl);
      else n_pass++;
      n_total++;
      if (alu_out !== e.alu)
        $display("FAIL %s_%s_alu got %h want %h", tag, e.name, alu_out, e.alu);
      else n_pass++;
      n_total++;
      if (zero !== e.z)
        $display("FAIL %s_%s_zero got %b want %b", tag, e.name, zero, e.z);
      else n_pass++;
    end
  endtask

  task automatic test_alu();
    vec_t v[] = '{
      '{"addu", RT, ADU, 32'h7FFFFFFF, 32'h1, 32'h0, 9'b00_00_01_00_1, 32'h80000000, 1'b0},
      '{"subu", RT, SBU, 32'h0, 32'h1, 32'h0, 9'b00_00_01_00_1, 32'hFFFFFFFF, 1'b0},
      '{"ori", ORI, 6'h0, 32'h12340000, 32'h5, 32'h0000FFFF, 9'b00_00_00_00_1, 32'h1234FFFF, 1'b0},
      '{"lui", LUI, 6'h0, 32'h55555555, 32'h7, 32'hABCD0000, 9'b10_00_00_00_1, 32'hABCD0000, 1'b0}
    };
    test_decode("alu", v);
  endtask

  task automatic test_control();
    vec_t v[] = '{
      '{"beq_eq", BEQ, 6'h0, 32'h5, 32'h5, 32'h0, 9'b00_01_00_00_0, 32'h0, 1'b1},
      '{"beq_ne", BEQ, 6'h0, 32'h5, 32'h6, 32'h0, 9'b00_00_00_00_0, 32'hFFFFFFFF, 1'b0},
      '{"jal", JAL, 6'h0, 32'h0, 32'h0, 32'h0, 9'b00_10_10_10_1, 32'h0, 1'b1},
      '{"jr", RT, JR, 32'h0, 32'h0, 32'h0, 9'b00_11_00_00_0, 32'h0, 1'b1},
      '{"j", J, 6'h0, 32'h0, 32'h0, 32'h0, 9'b00_10_00_00_0, 32'h0, 1'b1},
      '{"nop", RT, 6'h0, 32'h0, 32'h0, 32'h0, 9'b0, 32'h0, 1'b1},
      '{"bad_op", 6'h3F, 6'h0, 32'h0, 32'h0, 32'h0, 9'b0, 32'h0, 1'b1},
      '{"bad_fn", RT, 6'b100000, 32'h0, 32'h0, 32'h0, 9'b0, 32'h0, 1'b1},
      '{"sw", SW, 6'h0, 32'h0, 32'h0, 32'h10, 9'b01_00_00_00_0, 32'h10, 1'b0},
      '{"lw", LW, 6'h0, 32'h0, 32'h0, 32'h10, 9'b01_00_00_01_1, 32'h10, 1'b0}
    };
    test_decode("ctl", v);
  endtask

  task automatic test_mem();
    logic [31:0] e;
    issue(SW, 6'h0, 32'h0, 32'hDEADBEEF, 32'h8);
    data_q.push_back(32'hDEADBEEF);
    issue(LW, 6'h0, 32'h0, 32'h0, 32'h8);
    e = data_q.pop_front();
    n_total++;
    if (mem_rdata !== e) $display("FAIL lw_rd got %h want %h", mem_rdata, e);
    else n_pass++;
    n_total++;
    if (wd_sel !== 2'b01) $display("FAIL lw_wdsel got %b want 01", wd_sel);
    else n_pass++;
    issue(SW, 6'h0, 32'h0, 32'hCAFEF00D, 32'h8);
    n_total++;
    if (mem_rdata !== 32'hDEADBEEF)
      $display("FAIL rdw_old got %h want deadbeef", mem_rdata);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (mem_rdata !== 32'hCAFEF00D)
      $display("FAIL rdw_new got %h want cafef00d", mem_rdata);
    else n_pass++;
  endtask

  task automatic test_alias();
    logic [31:0] e;
    issue(SW, 6'h0, 32'h1000, 32'h13572468, 32'h0);
    data_q.push_back(32'h13572468);
    issue(LW, 6'h0, 32'h0, 32'h0, 32'h0);
    e = data_q[0];
    n_total++;
    if (mem_rdata !== e) $display("FAIL alias_wrap got %h want %h", mem_rdata, e);
    else n_pass++;
    issue(LW, 6'h0, 32'h0, 32'h0, 32'h3);
    e = data_q.pop_front();
    n_total++;
    if (mem_rdata !== e) $display("FAIL alias_lsb got %h want %h", mem_rdata, e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] e;
    for (int i = 0; i < 16; i++) begin
      d = $urandom | 32'h1;
      issue(SW, 6'h0, 32'h100, d, 32'(4 * i));
      data_q.push_back(d);
    end
    for (int i = 0; i < 16; i++) begin
      issue(LW, 6'h0, 32'h100, 32'h0, 32'(4 * i));
      e = data_q.pop_front();
      n_total++;
      if (mem_rdata !== e)
        $display("FAIL b2b_%0d got %h want %h", i, mem_rdata, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    issue(LW, 6'h0, 32'h100, 32'h0, 32'h4);
    reset = 1'b1;
    #1;
    n_total++;
    if (mem_rdata !== 32'h0) $display("FAIL rmid_clear got %h want 0", mem_rdata);
    else n_pass++;
    issue(SW, 6'h0, 32'h100, 32'h1111, 32'h0);
    issue(LW, 6'h0, 32'h100, 32'h0, 32'h0);
    n_total++;
    if (mem_rdata !== 32'h0) $display("FAIL rmid_blk got %h want 0", mem_rdata);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    issue(LW, 6'h0, 32'h100, 32'h0, 32'h0);
    n_total++;
    if (mem_rdata !== 32'h0) $display("FAIL rmid_after got %h want 0", mem_rdata);
    else n_pass++;
    issue(SW, 6'h0, 32'h100, 32'h2222, 32'h0);
    issue(LW, 6'h0, 32'h100, 32'h0, 32'h0);
    n_total++;
    if (mem_rdata !== 32'h2222) $display("FAIL rmid_wr got %h want 2222", mem_rdata);
    else n_pass++;
  endtask

  initial begin
    #1 reset = 1'b1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_alu();
    test_control();
    test_mem();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_mem_core.md
Name: exec_mem_core

Overview:
- Combined execute/memory/decode slice of the single-cycle MIPS datapath: main control decoder, 32-bit ALU with operand-B select, and word-addressed data memory.
- Sits between the register file/immediate extender (operands in) and the write-back mux/next-PC logic (control and data out).
- Supported instructions: addu, subu, ori, lw, sw, beq, lui, j, jal, jr, nop.

Parameters:
- DM_WORDS, 1024, data memory depth in 32-bit words (4 KiB); power of two.
- DM_AW, 10, word index width, log2(DM_WORDS).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears data memory
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- rs_val  in  32  register operand A (RD1)
- rt_val  in  32  register operand B and store data (RD2)
- ext_imm  in  32  extended immediate from the extender
- pc  in  32  current PC; used only by the trace feature
- ext_op  out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
- npc_op  out  2  00 pc+4, 01 branch, 10 j/jal target, 11 jr (rs)
- wr_sel  out  2  00 rt, 01 rd, 10 $31
- wd_sel  out  2  00 ALU, 01 mem, 10 pc+4
- rf_we  out  1  register file write enable
- alu_out  out  32  ALU result; also the data memory byte address
- zero  out  1  high when alu_out == 0
- mem_rdata  out  32  data memory read word

Behaviour:
- All outputs except memory state are combinational. There are no pipeline registers.
- Internal signals:
  - alu_op: 00 add, 01 sub, 10 or, 11 pass-B.
  - b_sel: 0 selects rt_val, 1 selects ext_imm.
  - dm_we: data memory write enable.
- ALU:
  - A = rs_val; B = b_sel ? ext_imm : rt_val.
  - add and sub are modulo 2^32 with no overflow detection. Example: 0 − 1 = FFFFFFFF.
- Decode, listed as alu_op / b_sel / ext_op / rf_we / dm_we / wr_sel / wd_sel / npc_op:
  - addu (000000/100001): 00/0/xx/1/0/01/00/00
  - subu (000000/100011): 01/0/xx/1/0/01/00/00
  - jr (000000/001000): rf_we=0, dm_we=0, npc_op=11
  - ori (001101): 10/1/00/1/0/00/00/00
  - lw (100011): 00/1/01/1/0/00/01/00
  - sw (101011): 00/1/01/0/1/xx/xx/00
  - beq (000100): 01/0/xx/0/0; npc_op = zero ? 01 : 00
  - lui (001111): 11/1/10/1/0/00/00/00
  - jal (000011): rf_we=1, wr_sel=10, wd_sel=10, npc_op=10
  - j (000010): rf_we=0, npc_op=10
- Any unlisted opcode/funct combination, including nop (all-zero instruction), drives every control output to 0: no register write, no memory write, npc_op=00. Every "xx" field above is driven to 0.
- Data memory, read:
  - Word index = alu_out[DM_AW+1:2]. Address bits [1:0] and bits above DM_AW+1 are ignored; addresses alias/wrap.
  - Read is combinational: mem_rdata = mem[index].
- Data memory, write: on rising clk, if dm_we and not reset, mem[index] <= rt_val.
  - Read-during-write returns the old word until the edge, then the new word.
- Data memory, reset: while reset is high, every word is 0 immediately (asynchronous), and writes are blocked.
  - Reset asserted mid-sequence discards all stored data.

Optional Feature:
- EXEC_MEM_TRACE_EN defined: on each rising clk with reset low and dm_we high, print "@<pc 8-hex>: *<alu_out 8-hex> <= <rt_val 8-hex>".
- Not defined: no simulation output; RTL is otherwise identical.
- The trace is simulation-only and not synthesized.

Decomposition:
- Shared package exec_mem_pkg holds:
  - opcode constants: OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_J, OP_JAL
  - funct constants: FN_ADDU, FN_SUBU, FN_JR
  - enums for alu_op, ext_op, npc_op, wr_sel, wd_sel
- One natural sub-module: exec_mem_dm (memory array, async clear, sync write, comb read).
- Decoder and ALU remain inline.

Test Plan:
- addu, rs=7FFFFFFF, rt=00000001 -> alu_out=80000000, rf_we=1, wr_sel=01, wd_sel=00; subu 0−1 -> FFFFFFFF, zero=0.
- ori, rs=12340000, ext_imm=0000FFFF -> alu_out=1234FFFF, ext_op=00, b_sel path used.
- lui, ext_imm=ABCD0000 -> alu_out=ABCD0000, ext_op=10.
- sw, rs=0, ext_imm=8, rt=DEADBEEF, clock edge -> lw with same address gives mem_rdata=DEADBEEF, wd_sel=01.
- Address alias: sw at byte address 0x1000 (DM_WORDS=1024) -> lw at byte address 0 returns the stored word.
- beq, rs=rt=5 -> zero=1, npc_op=01; rs=5, rt=6 -> npc_op=00.
- jal -> wr_sel=10, wd_sel=10, npc_op=10, rf_we=1; jr -> npc_op=11, rf_we=0; opcode 111111 -> all controls 0.
- Store words, assert reset between clock edges -> mem_rdata reads 0 immediately; sw issued during reset writes nothing.
